// File: rtl/alu_dispatch.sv
// alu_dispatch
// Issue-side dispatcher for the ALU. Accepts one operation per start/ready
// handshake, registers operands and sub-op for the execution units, decodes
// the op class into a one-hot unit select and sequences the multi-cycle
// muldiv unit through its valid return. Completion is a one-cycle done_out
// pulse aligned with the cycle in which the selected unit result is valid.
//
// Optional feature macro: ALU_DISPATCH_TIMEOUT_EN
//   defined   : muldiv wait counter and MD_WAIT -> ERR timeout are built in
//   undefined : MD_WAIT waits indefinitely; err_out flags illegal ops only
//
// Ports
//   clk              in   rising-edge clock
//   rst              in   synchronous active-high reset
//   start_in         in   request, accepted only while ready_out = 1
//   op_in            in   opcode [op_wl-1:op_wl-2] class, rest sub-op
//   a_in, b_in       in   operands, sampled on accept
//   ready_out        out  idle, can accept
//   a_out, b_out     out  registered operands to all units
//   func_out         out  registered sub-op to all units
//   active_vec       out  one-hot unit select (arith, logic, shift, muldiv)
//   muldiv_start_out out  one-cycle muldiv launch pulse
//   valid_in_muldiv  in   muldiv result ready
//   done_out         out  one-cycle completion pulse
//   err_out          out  one-cycle error pulse, coincident with done_out
//
// All outputs are registered; they are loaded from the decode of the next
// state so they line up with the state they belong to.

module alu_dispatch #(
    parameter int data_wl    = 16,
    parameter int op_wl      = 8,
    parameter int md_timeout = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_in,
    input  logic [op_wl-1:0]    op_in,
    input  logic [data_wl-1:0]  a_in,
    input  logic [data_wl-1:0]  b_in,
    output logic                ready_out,
    output logic [data_wl-1:0]  a_out,
    output logic [data_wl-1:0]  b_out,
    output logic [op_wl-3:0]    func_out,
    output logic [3:0]          active_vec,
    output logic                muldiv_start_out,
    input  logic                valid_in_muldiv,
    output logic                done_out,
    output logic                err_out
);

    // The wait counter needs at least two values to be meaningful.
    if (md_timeout < 2) begin : g_param_check
        $error("alu_dispatch: md_timeout must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_EXEC     = 3'd1,
        S_MD_START = 3'd2,
        S_MD_WAIT  = 3'd3,
        S_MD_DONE  = 3'd4,
        S_ERR      = 3'd5
    } state_t;

    localparam logic [1:0] CLS_MULDIV = 2'b11;

    state_t      state_r;
    state_t      state_s;
    logic [1:0]  cls_r;
    logic [1:0]  cls_s;
    logic        accept_s;
    logic        illegal_s;
    logic [3:0]  active_s;
    logic        done_s;
    logic        err_s;
    logic        md_start_s;
    logic        ready_s;

`ifdef ALU_DISPATCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(md_timeout);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(md_timeout - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
`endif

    // Only four muldiv sub-ops exist: sub-op bits above [1:0] must be zero.
    always_comb begin
        illegal_s = 1'b0;
        if ((op_in[op_wl-1:op_wl-2] == CLS_MULDIV) &&
            (op_in[op_wl-3:2] != {(op_wl-4){1'b0}})) begin
            illegal_s = 1'b1;
        end else begin
            illegal_s = 1'b0;
        end
    end

    // Next-state logic, accept decision and wait-counter update.
    always_comb begin
        state_s  = state_r;
        cls_s    = cls_r;
        accept_s = 1'b0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
        cnt_s    = cnt_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (start_in) begin
                    accept_s = 1'b1;
                    cls_s    = op_in[op_wl-1:op_wl-2];
                    if (illegal_s) begin
                        state_s = S_ERR;
                    end else if (op_in[op_wl-1:op_wl-2] == CLS_MULDIV) begin
                        state_s = S_MD_START;
                    end else begin
                        state_s = S_EXEC;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_EXEC: begin
                state_s = S_IDLE;
            end
            S_MD_START: begin
`ifdef ALU_DISPATCH_TIMEOUT_EN
                cnt_s = '0;
`endif
                state_s = S_MD_WAIT;
            end
            S_MD_WAIT: begin
                // A valid arriving on the timeout cycle still completes normally.
                if (valid_in_muldiv) begin
                    state_s = S_MD_DONE;
`ifdef ALU_DISPATCH_TIMEOUT_EN
                end else if (cnt_r == CNT_MAX) begin
                    state_s = S_ERR;
                end else begin
                    cnt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_s = S_MD_WAIT;
                end
`else
                end else begin
                    state_s = S_MD_WAIT;
                end
`endif
            end
            S_MD_DONE: begin
                state_s = S_IDLE;
            end
            S_ERR: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Output decode of the next state, registered below.
    always_comb begin
        active_s   = 4'b0000;
        done_s     = 1'b0;
        err_s      = 1'b0;
        md_start_s = 1'b0;
        ready_s    = 1'b0;
        case (state_s)
            S_IDLE: begin
                ready_s = 1'b1;
            end
            S_EXEC: begin
                active_s = 4'(4'b0001 << cls_s);
                done_s   = 1'b1;
            end
            S_MD_START: begin
                active_s   = 4'b1000;
                md_start_s = 1'b1;
            end
            S_MD_WAIT: begin
                active_s = 4'b1000;
            end
            S_MD_DONE: begin
                active_s = 4'b1000;
                done_s   = 1'b1;
            end
            S_ERR: begin
                done_s = 1'b1;
                err_s  = 1'b1;
            end
            default: begin
                active_s = 4'b0000;
            end
        endcase
    end

    // State, operand and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= S_IDLE;
            cls_r            <= 2'b00;
            a_out            <= '0;
            b_out            <= '0;
            func_out         <= '0;
            active_vec       <= 4'b0000;
            muldiv_start_out <= 1'b0;
            done_out         <= 1'b0;
            err_out          <= 1'b0;
            ready_out        <= 1'b1;
        end else begin
            state_r          <= state_s;
            cls_r            <= cls_s;
            active_vec       <= active_s;
            muldiv_start_out <= md_start_s;
            done_out         <= done_s;
            err_out          <= err_s;
            ready_out        <= ready_s;
            if (accept_s) begin
                a_out    <= a_in;
                b_out    <= b_in;
                func_out <= op_in[op_wl-3:0];
            end else begin
                a_out    <= a_out;
                b_out    <= b_out;
                func_out <= func_out;
            end
        end
    end

`ifdef ALU_DISPATCH_TIMEOUT_EN
    // Muldiv wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_s;
        end
    end
`endif

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch. Expected behaviour is derived per
// transaction from the opcode: class selects the one-hot unit, muldiv ops
// with nonzero upper sub-op bits are illegal, muldiv completes one cycle
// after the sampled valid.

module tb_alu_dispatch;

    localparam int DW  = 16;
    localparam int OW  = 8;
    localparam int MDT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_in;
    logic [OW-1:0] op_in;
    logic [DW-1:0] a_in;
    logic [DW-1:0] b_in;
    logic          ready_out;
    logic [DW-1:0] a_out;
    logic [DW-1:0] b_out;
    logic [OW-3:0] func_out;
    logic [3:0]    active_vec;
    logic          muldiv_start_out;
    logic          valid_in_muldiv;
    logic          done_out;
    logic          err_out;

    int checks = 0;
    int errors = 0;

    alu_dispatch #(.data_wl(DW), .op_wl(OW), .md_timeout(MDT)) dut (
        .clk              (clk),
        .rst              (rst),
        .start_in         (start_in),
        .op_in            (op_in),
        .a_in             (a_in),
        .b_in             (b_in),
        .ready_out        (ready_out),
        .a_out            (a_out),
        .b_out            (b_out),
        .func_out         (func_out),
        .active_vec       (active_vec),
        .muldiv_start_out (muldiv_start_out),
        .valid_in_muldiv  (valid_in_muldiv),
        .done_out         (done_out),
        .err_out          (err_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // One full transaction: drive an op from IDLE and check every cycle until
    // the block is idle again. lat = MD_WAIT cycles before valid is raised (>=1).
    task automatic exec_op(input logic [7:0] op, input logic [15:0] a,
                           input logic [15:0] b, input int lat, input string tag);
        logic [1:0] cls;
        logic       ill;
        logic [3:0] exp_act;
        cls = op[7:6];
        ill = (cls == 2'd3) && (op[5:2] != 4'd0);
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL %s ready_pre: got %b want 1", tag, ready_out); end
        start_in = 1'b1; op_in = op; a_in = a; b_in = b;
        @(negedge clk);
        start_in = 1'b0; op_in = OW'($urandom); a_in = DW'($urandom); b_in = DW'($urandom);
        checks++; if ({a_out, b_out} !== {a, b}) begin errors++; $display("FAIL %s operands: got %h %h want %h %h", tag, a_out, b_out, a, b); end
        checks++; if (func_out !== op[5:0]) begin errors++; $display("FAIL %s func: got %h want %h", tag, func_out, op[5:0]); end
        checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL %s ready_busy: got %b want 0", tag, ready_out); end
        if (ill) begin
            checks++; if ({active_vec, muldiv_start_out, done_out, err_out} !== 7'b0000_011) begin
                errors++; $display("FAIL %s illegal: got act=%b st=%b d=%b e=%b want act=0000 st=0 d=1 e=1", tag, active_vec, muldiv_start_out, done_out, err_out); end
        end else if (cls != 2'd3) begin
            exp_act = 4'b0001 << cls;
            checks++; if ({active_vec, muldiv_start_out, done_out, err_out} !== {exp_act, 3'b010}) begin
                errors++; $display("FAIL %s single: got act=%b st=%b d=%b e=%b want act=%b st=0 d=1 e=0", tag, active_vec, muldiv_start_out, done_out, err_out, exp_act); end
        end else begin
            checks++; if ({active_vec, muldiv_start_out, done_out, err_out} !== 7'b1000_100) begin
                errors++; $display("FAIL %s md_start: got act=%b st=%b d=%b e=%b want act=1000 st=1 d=0 e=0", tag, active_vec, muldiv_start_out, done_out, err_out); end
            for (int i = 0; i < lat; i++) begin
                @(negedge clk);
                checks++; if ({active_vec, muldiv_start_out, done_out, err_out} !== 7'b1000_000) begin
                    errors++; $display("FAIL %s md_wait%0d: got act=%b st=%b d=%b e=%b want act=1000 st=0 d=0 e=0", tag, i, active_vec, muldiv_start_out, done_out, err_out); end
            end
            valid_in_muldiv = 1'b1;
            @(negedge clk);
            valid_in_muldiv = 1'b0;
            checks++; if ({active_vec, muldiv_start_out, done_out, err_out} !== 7'b1000_010) begin
                errors++; $display("FAIL %s md_done: got act=%b st=%b d=%b e=%b want act=1000 st=0 d=1 e=0", tag, active_vec, muldiv_start_out, done_out, err_out); end
        end
        @(negedge clk);
        checks++; if ({ready_out, active_vec, done_out, err_out, muldiv_start_out} !== 8'b1_0000_000) begin
            errors++; $display("FAIL %s idle_after: got rdy=%b act=%b d=%b e=%b st=%b want rdy=1 rest 0", tag, ready_out, active_vec, done_out, err_out, muldiv_start_out); end
        checks++; if ({a_out, b_out, func_out} !== {a, b, op[5:0]}) begin
            errors++; $display("FAIL %s hold: got %h %h %h want %h %h %h", tag, a_out, b_out, func_out, a, b, op[5:0]); end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_in = 1'b1; op_in = 8'h05; a_in = 16'hFFFF; b_in = 16'hFFFF; valid_in_muldiv = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if ({ready_out, active_vec, muldiv_start_out, done_out, err_out} !== 8'b1_0000_000) begin
                errors++; $display("FAIL reset_ctrl%0d: got rdy=%b act=%b st=%b d=%b e=%b want rdy=1 rest 0", i, ready_out, active_vec, muldiv_start_out, done_out, err_out); end
            checks++; if ({a_out, b_out, func_out} !== 38'd0) begin
                errors++; $display("FAIL reset_data%0d: got %h %h %h want 0", i, a_out, b_out, func_out); end
        end
        rst = 1'b0; start_in = 1'b0;
        @(negedge clk);
        checks++; if ({ready_out, active_vec, done_out} !== 6'b1_0000_0) begin
            errors++; $display("FAIL reset_noaccept: got rdy=%b act=%b d=%b want rdy=1 act=0000 d=0", ready_out, active_vec, done_out); end
    endtask

    task automatic test_arith();
        exec_op(8'h05, 16'h1234, 16'h0001, 1, "arith");
    endtask

    task automatic test_back_to_back();
        start_in = 1'b1; op_in = 8'h41; a_in = 16'hAAAA; b_in = 16'h5555;
        @(negedge clk);
        checks++; if ({active_vec, done_out, ready_out, func_out} !== {4'b0010, 1'b1, 1'b0, 6'h01}) begin
            errors++; $display("FAIL b2b_first: got act=%b d=%b rdy=%b f=%h want act=0010 d=1 rdy=0 f=01", active_vec, done_out, ready_out, func_out); end
        op_in = 8'h82; a_in = 16'h0F0F;
        @(negedge clk);
        checks++; if ({ready_out, done_out, active_vec, func_out} !== {1'b1, 1'b0, 4'b0000, 6'h01}) begin
            errors++; $display("FAIL b2b_gap: got rdy=%b d=%b act=%b f=%h want rdy=1 d=0 act=0000 f=01", ready_out, done_out, active_vec, func_out); end
        @(negedge clk);
        start_in = 1'b0;
        checks++; if ({active_vec, done_out, func_out, a_out} !== {4'b0100, 1'b1, 6'h02, 16'h0F0F}) begin
            errors++; $display("FAIL b2b_second: got act=%b d=%b f=%h a=%h want act=0100 d=1 f=02 a=0f0f", active_vec, done_out, func_out, a_out); end
        @(negedge clk);
        checks++; if ({ready_out, done_out} !== 2'b10) begin
            errors++; $display("FAIL b2b_end: got rdy=%b d=%b want rdy=1 d=0", ready_out, done_out); end
    endtask

    task automatic test_muldiv();
        exec_op(8'hC1, 16'h0007, 16'h0003, 5, "muldiv5");
        exec_op(8'hC3, 16'h1111, 16'h2222, 1, "muldiv1");
        // Valid coincides with the last wait cycle of the timeout build.
        exec_op(8'hC2, 16'h3333, 16'h4444, MDT, "muldiv_edge");
    endtask

    task automatic test_illegal_and_stray_valid();
        exec_op(8'hD0, 16'h0102, 16'h0304, 1, "illegal_d0");
        exec_op(8'hFF, 16'h0506, 16'h0708, 1, "illegal_ff");
        valid_in_muldiv = 1'b1;
        exec_op(8'h3A, 16'hBEEF, 16'hCAFE, 1, "stray_arith");
        exec_op(8'hE4, 16'h0000, 16'hFFFF, 1, "stray_illegal");
        valid_in_muldiv = 1'b0;
    endtask

    task automatic test_timeout();
        start_in = 1'b1; op_in = 8'hC0; a_in = 16'h0001; b_in = 16'h0002;
        @(negedge clk);
        start_in = 1'b0;
        checks++; if (muldiv_start_out !== 1'b1) begin errors++; $display("FAIL to_start: got %b want 1", muldiv_start_out); end
`ifdef ALU_DISPATCH_TIMEOUT_EN
        for (int i = 0; i < MDT; i++) begin
            @(negedge clk);
            checks++; if ({active_vec, done_out, err_out} !== 6'b1000_00) begin
                errors++; $display("FAIL to_wait%0d: got act=%b d=%b e=%b want act=1000 d=0 e=0", i, active_vec, done_out, err_out); end
        end
        @(negedge clk);
        checks++; if ({active_vec, done_out, err_out} !== 6'b0000_11) begin
            errors++; $display("FAIL to_err: got act=%b d=%b e=%b want act=0000 d=1 e=1", active_vec, done_out, err_out); end
`else
        for (int i = 0; i < 4 * MDT; i++) begin
            @(negedge clk);
            checks++; if ({active_vec, done_out, err_out} !== 6'b1000_00) begin
                errors++; $display("FAIL to_wait%0d: got act=%b d=%b e=%b want act=1000 d=0 e=0", i, active_vec, done_out, err_out); end
        end
        valid_in_muldiv = 1'b1;
        @(negedge clk);
        valid_in_muldiv = 1'b0;
        checks++; if ({active_vec, done_out, err_out} !== 6'b1000_10) begin
            errors++; $display("FAIL to_late_done: got act=%b d=%b e=%b want act=1000 d=1 e=0", active_vec, done_out, err_out); end
`endif
        @(negedge clk);
        checks++; if ({ready_out, done_out, err_out} !== 3'b100) begin
            errors++; $display("FAIL to_idle: got rdy=%b d=%b e=%b want rdy=1 d=0 e=0", ready_out, done_out, err_out); end
    endtask

    task automatic test_reset_mid();
        start_in = 1'b1; op_in = 8'hC1; a_in = 16'h9999; b_in = 16'h8888;
        @(negedge clk);
        start_in = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({ready_out, active_vec, muldiv_start_out, done_out, err_out, a_out} !== {8'b1_0000_000, 16'h0000}) begin
            errors++; $display("FAIL midrst_state: got rdy=%b act=%b st=%b d=%b e=%b a=%h want rdy=1 rest 0", ready_out, active_vec, muldiv_start_out, done_out, err_out, a_out); end
        valid_in_muldiv = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if ({ready_out, active_vec, muldiv_start_out, done_out, err_out} !== 8'b1_0000_000) begin
                errors++; $display("FAIL midrst_valid%0d: got rdy=%b act=%b st=%b d=%b e=%b want rdy=1 rest 0", i, ready_out, active_vec, muldiv_start_out, done_out, err_out); end
        end
        valid_in_muldiv = 1'b0;
        exec_op(8'h00, 16'h4321, 16'h8765, 1, "after_midrst");
    endtask

    task automatic test_random();
        logic [7:0] op;
        for (int n = 0; n < 40; n++) begin
            op = 8'($urandom);
            if ($urandom_range(0, 2) == 0) op = {2'b11, 4'b0000, op[1:0]};
            exec_op(op, 16'($urandom), 16'($urandom), int'($urandom_range(1, MDT)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_muldiv();
        test_illegal_and_stray_valid();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Issue-side counterpart of the ALU result selector. Accepts one operation at a time on a start/ready handshake and decodes the op class into the one-hot `active_vec` consumed by the selector. Registers the operands and sub-op for the arithmetic, logic, shift and muldiv units, and sequences the multi-cycle muldiv unit through its `valid_in_muldiv` return. Signals completion with a single-cycle `done_out`, aligned to the cycle in which the selector output is valid.

## Interface
Parameters:
- `data_wl`, 16, operand width
- `op_wl`, 8, opcode width; bits [op_wl-1:op_wl-2] = class, rest = sub-op
- `md_timeout`, 64, max cycles waited for `valid_in_muldiv` (≥2)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  sole clock, rising edge
  - `rst`  in  1  synchronous, active-high reset
- Handshake and operands in:
  - `start_in`  in  1  request; accepted only when `ready_out`=1
  - `op_in`  in  op_wl  opcode, sampled on accept
  - `a_in`, `b_in`  in  data_wl  operands, sampled on accept
- Registered outputs to units and selector:
  - `ready_out`  out  1  block idle, can accept
  - `a_out`, `b_out`  out  data_wl  registered operands to all units
  - `func_out`  out  op_wl-2  registered sub-op to all units
  - `active_vec`  out  4  one-hot unit select to selector: 0001 arith, 0010 logic, 0100 shift, 1000 muldiv
  - `muldiv_start_out`  out  1  one-cycle launch pulse to muldiv
- Muldiv return:
  - `valid_in_muldiv`  in  1  muldiv result ready; muldiv holds result until next launch
- Completion:
  - `done_out`  out  1  one-cycle completion pulse
  - `err_out`  out  1  one-cycle error pulse, coincident with `done_out`

## Operation
- Class decode: 00 arith, 01 logic, 10 shift, 11 muldiv.
- Illegal op: class 11 with sub-op bits above [1:0] nonzero. Only 4 muldiv sub-ops exist.
- FSM states and their outputs:
  - IDLE: `ready_out`=1, `active_vec`=0000.
    - `start_in`=1: latch op, a and b into `func_out`/`a_out`/`b_out`.
    - Next state: ERR if illegal, MD_START if class 11, else EXEC.
  - EXEC: `active_vec`=class one-hot, `done_out`=1 → IDLE.
  - MD_START: `active_vec`=1000, `muldiv_start_out`=1, clear wait counter → MD_WAIT.
  - MD_WAIT: `active_vec`=1000, counter += 1.
    - `valid_in_muldiv`=1 → MD_DONE.
    - Else, counter = md_timeout-1 → ERR (timeout build only).
  - MD_DONE: `active_vec`=1000, `done_out`=1 → IDLE.
  - ERR: `active_vec`=0000, `done_out`=1, `err_out`=1 → IDLE.
- Rules:
  - All outputs are Moore: decoded from state or from registers only; no input→output combinational path.
  - `start_in` while `ready_out`=0 is ignored (not queued).
  - `valid_in_muldiv` outside MD_WAIT is ignored.
  - If `valid_in_muldiv` and timeout coincide in the same cycle, valid wins → MD_DONE.
  - Wait counter is clog2(md_timeout) bits and never wraps; it saturates at the timeout compare.
  - `a_out`/`b_out`/`func_out` hold their value until the next accept.

## Timing
- Reset (`rst`=1 at a clock edge) → IDLE:
  - `ready_out`=1.
  - `active_vec`=0, `a_out`=0, `b_out`=0, `func_out`=0, `muldiv_start_out`=0, `done_out`=0, `err_out`=0.
  - Wait counter = 0.
- Single-cycle units: accept at edge N; `active_vec`/`done_out` valid in cycle N+1; `ready_out`=1 again in N+2.
  - Throughput: 1 op per 2 cycles.
- Muldiv: accept at N; `muldiv_start_out` in N+1; MD_WAIT from N+2.
  - `valid_in_muldiv` sampled high at edge M → `done_out` in cycle M+1.
- Illegal op: accept at N; `done_out`=`err_out`=1 in N+1.
- Reset mid-operation (any state): return to IDLE next edge.
  - No `done_out`, no `err_out`; no `muldiv_start_out` reissue.
  - Muldiv unit reset is the system's responsibility.

## Configuration
- `ALU_DISPATCH_TIMEOUT_EN` defined:
  - Wait counter and MD_WAIT→ERR timeout compiled in.
  - `err_out` flags illegal ops and timeouts.
- Not defined:
  - No counter; MD_WAIT waits indefinitely for `valid_in_muldiv`.
  - `err_out` flags illegal ops only; `md_timeout` is unused.

## Test plan
- Reset: hold `rst` 2 cycles with `start_in`=1 → `ready_out`=1, all other outputs 0, no accept during reset.
- Arith: `op_in`=8'h05, a=16'h1234, b=16'h0001, `start_in` pulse → next cycle `active_vec`=0001, `func_out`=6'h05, `a_out`=16'h1234, `done_out`=1; cycle after, `ready_out`=1.
- Back-to-back: `start_in` held high with ops 8'h41 then 8'h82 → accepted 2 cycles apart; `active_vec` 0010 then 0100, each with one `done_out`.
- Muldiv: `op_in`=8'hC1, `valid_in_muldiv` driven 5 cycles after `muldiv_start_out` → exactly one start pulse, `active_vec`=1000 throughout, `done_out` one cycle after valid, `err_out`=0.
- Illegal/timeout: `op_in`=8'hD0 → `done_out`=`err_out`=1 next cycle, no `muldiv_start_out`. `op_in`=8'hC0 with valid never asserted and `md_timeout`=8 (TIMEOUT_EN defined) → `err_out` 8 cycles after entering MD_WAIT.
- Reset mid-MD_WAIT, then `valid_in_muldiv`=1 → IDLE, no `done_out`, valid ignored, next op 8'h00 completes normally.
